iter_mul_unit: RTL
==================

# iter_mul_unit

Parametrised, multi-cycle multiply/multiply-accumulate unit for the ARM datapath. It covers MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. It replaces the single-cycle combinational multiplier. It computes `BPC` multiplier bits per cycle under a start/busy/done handshake, so the multiply no longer sits on the critical path. The control unit stalls the PC and register write-back while `busy` is high. It commits `ret1`/`ret2` to register write ports 1/3 on `done`. The unit also produces N/Z flags for the S-suffixed variants.

## Interface
- `WIDTH`, 32, operand width. Results are `WIDTH` bits each. The long product is 2·`WIDTH`.
- `BPC`, 4, multiplier bits retired per iteration cycle. Must divide `WIDTH`. `BPC`=`WIDTH` is legal and gives single-iteration operation.
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `cmd`  in  3  operation, sampled with `start`.
- `a`, `b`  in  `WIDTH`  multiplicand and multiplier (Rm, Rs).
- `c`  in  `WIDTH`  accumulate high word (RdHi).
- `d`  in  `WIDTH`  accumulate low word (RdLo / Rn for MLA).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse. Results are valid in this cycle.
- `ret1`  out  `WIDTH`  high result word.
- `ret2`  out  `WIDTH`  low result word.
- `n`, `z`  out  1  negative / zero flags of the result.

## Operation
- `cmd` encoding:
  - 000 MUL: `ret2` = (a·b)[W-1:0].
  - 001 MLA: `ret2` = (a·b + d)[W-1:0].
  - 100 UMULL: {`ret1`,`ret2`} = a·b, unsigned.
  - 101 UMLAL: {`ret1`,`ret2`} = a·b + {c,d}, unsigned.
  - 110 SMULL: {`ret1`,`ret2`} = a·b, signed.
  - 111 SMLAL: {`ret1`,`ret2`} = a·b + {c,d}, signed.
  - 010 and 011 execute as MUL.
- `ret1` = 0 for MUL/MLA.
- All sums are modulo 2^(2W). Overflow is discarded silently.
- FSM states:
  - IDLE: `start`=1 → LOAD actions and go to RUN. `cmd`, a, b, c, d are registered. For signed commands, a and b are replaced by their magnitudes and the result-sign bit (a[W-1]^b[W-1]) is stored. The partial product is cleared and the iteration counter is loaded with `WIDTH`/`BPC`.
  - RUN: each cycle adds (mag_a · next `BPC` bits of mag_b) into the 2W-bit partial product, shifted to the correct position. Shift-add or a small radix table is acceptable. The counter decrements. At count=1 the next state is FIN.
  - FIN: conditionally negate the product (two's complement, 2W bits). Add the accumulator: {c,d} for long accumulate, zero-extended d for MLA, zero otherwise. Register `ret1`/`ret2`/`n`/`z`, pulse `done`, return to IDLE.
- Flags:
  - `n` = `ret1`[W-1] for long ops, `ret2`[W-1] for MUL/MLA.
  - `z` = (`ret1`,`ret2` all zero) for long ops, (`ret2`==0) for MUL/MLA.
- Signed magnitude of the most negative value (0x80000000) is 2^(W-1). The unsigned datapath must carry it exactly, so no extra sign bit is lost.
- Operands are captured at `start`. Input changes during RUN have no effect.
- `ret1`/`ret2`/`n`/`z` hold their values until the next FIN.

## Timing
- Reset (asynchronous, any state including mid-RUN): state IDLE, and `busy`, `done`, `ret1`, `ret2`, `n`, `z` all 0. No partial result is ever emitted. The first `start` after reset release behaves normally.
- Let S = `WIDTH`/`BPC`. When `start` is sampled at edge k:
  - `busy`=1 from after edge k until edge k+S+1.
  - Edges k+1…k+S are RUN iterations.
  - Edge k+S+1 is FIN: results are written, `done`=1 and `busy`=0 for exactly one cycle.
  - Total latency is S+1 edges: 9 for 32/4, 33 for `BPC`=1.
- `start` while `busy`=1 is ignored, with no queueing.
- `start` high during the `done` cycle is accepted. `busy`=0 there, so back-to-back operations issue every S+1 cycles.
- `done` is registered and is never high for two consecutive cycles.

## Test plan
- UMULL a=b=0xFFFFFFFF, `start` at edge k → `done` at edge k+9 only, `ret1`=0xFFFFFFFE, `ret2`=0x00000001, n=1, z=0, and `busy` high for exactly 9 cycles.
- SMULL a=0xFFFFFFFE (−2), b=3 → `ret1`=0xFFFFFFFF, `ret2`=0xFFFFFFFA, n=1. SMLAL a=b=0x80000000, c=0, d=1 → `ret1`=0x40000000, `ret2`=0x00000001, n=0.
- MLA a=7, b=6, d=0xFFFFFFD6 → `ret2`=0, `ret1`=0, z=1. MUL with `cmd`=010, a=5, b=9 → `ret2`=45.
- `start` re-asserted while busy with different operands → ignored, first result unchanged. `start` in the `done` cycle → second result after exactly 9 more edges.
- `reset` asserted at RUN cycle 4 → all outputs 0 immediately, with no `done`. After release, UMULL 3·4 → `ret2`=12 with normal latency.
- Parameter sweep `BPC`∈{1,2,8,32}, `WIDTH`∈{16,32}, with random signed/unsigned accumulate vs. a reference model → bit-exact results and latency S+1.

Source files
------------

// File: rtl/iter_mul_unit.sv
// iter_mul_unit: multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL retiring BPC multiplier bits per cycle
module iter_mul_unit #(
   parameter int WIDTH = 32,
   parameter int BPC   = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_cmd,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_ret1,
   output logic [WIDTH-1:0] o_ret2,
   output logic             o_n,
   output logic             o_z
);
   localparam int S  = WIDTH / BPC;
   localparam int CW = $clog2(S + 1);
   localparam int PW = 2 * WIDTH;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t           r_state;
   logic [2:0]       r_cmd;
   logic             r_neg;
   logic [PW-1:0]    r_mcand;
   logic [PW-1:0]    r_prod;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_c;
   logic [WIDTH-1:0] r_d;
   logic [CW-1:0]    r_cnt;
   logic             w_sgn;
   logic             w_long;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [PW-1:0]    w_pp;
   logic [PW-1:0]    w_signed;
   logic [PW-1:0]    w_acc;
   logic [PW-1:0]    w_res;
   // magnitudes stay WIDTH bits wide: the most negative value maps to 2^(WIDTH-1) exactly
   assign w_sgn    = i_cmd[2:1] == 2'b11;
   assign w_mag_a  = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_mag_b  = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
   assign w_pp     = r_mcand * PW'(r_mplier[BPC-1:0]);
   assign w_long   = r_cmd[2];
   assign w_signed = r_neg ? -r_prod : r_prod;
   assign w_acc    = (w_long && r_cmd[0]) ? {r_c, r_d} : (r_cmd == 3'b001) ? PW'(r_d) : '0;
   assign w_res    = w_signed + w_acc;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_cmd    <= '0;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_c      <= '0;
         r_d      <= '0;
         r_cnt    <= '0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_ret1   <= '0;
         o_ret2   <= '0;
         o_n      <= 1'b0;
         o_z      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            IDLE: if (i_start) begin
               r_state  <= RUN;
               o_busy   <= 1'b1;
               r_cmd    <= i_cmd;
               r_neg    <= w_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
               r_mcand  <= PW'(w_mag_a);
               r_mplier <= w_mag_b;
               r_c      <= i_c;
               r_d      <= i_d;
               r_prod   <= '0;
               r_cnt    <= CW'(S);
            end
            RUN: begin
               r_prod   <= r_prod + w_pp;
               r_mcand  <= r_mcand << BPC;
               r_mplier <= r_mplier >> BPC;
               r_cnt    <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) r_state <= FIN;
            end
            FIN: begin
               o_ret1  <= w_long ? w_res[PW-1:WIDTH] : '0;
               o_ret2  <= w_res[WIDTH-1:0];
               o_n     <= w_long ? w_res[PW-1] : w_res[WIDTH-1];
               o_z     <= w_long ? (w_res == '0) : (w_res[WIDTH-1:0] == '0);
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
